// File: rtl/parking_occupancy_pkg.sv
// Shared parking definitions: slot count, field widths, gate FSM states
// and the slot-vector helpers used to derive capacity and first_empty.
package parking_occupancy_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int CAP_W     = 3;
  localparam int IDX_W     = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } gate_state_e;

  function automatic logic [CAP_W-1:0] free_count(input logic [NUM_SLOTS-1:0] occ);
    logic [CAP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occ[i]) n = n + 1'b1;
    end
    return n;
  endfunction

  // Lowest empty slot after passing over the 'skip' lowest empty slots,
  // which are notionally reserved for cars already let through the gate.
  function automatic logic [IDX_W-1:0] first_free(input logic [NUM_SLOTS-1:0] occ,
                                                  input logic [CAP_W-1:0]     skip);
    logic [CAP_W-1:0] seen;
    logic [IDX_W-1:0] idx;
    logic             found;
    seen  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occ[i] && !found) begin
        if (seen == skip) begin
          idx   = IDX_W'(i);
          found = 1'b1;
        end else begin
          seen = seen + 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/parking_occupancy_debouncer.sv
// One slot sensor: 2-flop synchroniser followed by a run-length debouncer.
// rise_o flags the cycle whose clock edge will take the debounced bit 0->1.
module slot_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_500Hz,
  input  logic reset,
  input  logic sensor_i,
  output logic deb_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted value.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = deb_d & ~deb_q;

endmodule

// File: rtl/parking_occupancy.sv
// Parking lot occupancy tracker: debounced slot sensors, in-transit car
// accounting, registered capacity/first_empty and the entry gate FSM.
module parking_occupancy
  import parking_occupancy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GATE_CYCLES     = 10
) (
  input  logic                 clk_500Hz,
  input  logic                 reset,
  input  logic [NUM_SLOTS-1:0] slot_sensor,
  input  logic                 entry_req,
  output logic [CAP_W-1:0]     capacity,
  output logic [IDX_W-1:0]     first_empty,
  output logic                 full,
  output logic                 gate_open,
  output logic                 entry_deny
);

  localparam int               GCNT_W      = $clog2(GATE_CYCLES + 1);
  localparam logic [CAP_W-1:0] MAX_TRANSIT = CAP_W'(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] occ, rise;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    slot_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_500Hz(clk_500Hz),
      .reset    (reset),
      .sensor_i (slot_sensor[s]),
      .deb_o    (occ[s]),
      .rise_o   (rise[s])
    );
  end

  gate_state_e       state_q, state_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              req_q;
  logic [CAP_W-1:0]  transit_q, transit_d;
  logic [CAP_W-1:0]  capacity_q, capacity_d, free_raw;
  logic [IDX_W-1:0]  first_q, first_d;
  logic              full_q, full_d;
  logic              deny_q, deny_d;
  logic              req_edge, grant, any_rise;

  // Entry decision uses the registered capacity the driver currently sees.
  always_comb begin
    req_edge = entry_req & ~req_q;
    any_rise = |rise;
    grant    = (state_q == ST_IDLE) && req_edge && (capacity_q != '0);
    deny_d   = (state_q == ST_IDLE) && req_edge && (capacity_q == '0);
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_OPEN;
          gcnt_d  = GCNT_W'(GATE_CYCLES);
        end
      end
      ST_OPEN: begin
        if (gcnt_q == GCNT_W'(1)) begin
          state_d = ST_IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gcnt_d  = '0;
      end
    endcase
  end

  // A grant and a parking event in the same cycle cancel out.
  always_comb begin
    transit_d = transit_q;
    if (grant && !any_rise && (transit_q != MAX_TRANSIT)) begin
      transit_d = transit_q + 1'b1;
    end else if (any_rise && !grant && (transit_q != '0)) begin
      transit_d = transit_q - 1'b1;
    end
  end

  always_comb begin
    free_raw   = free_count(occ);
    capacity_d = (transit_q > free_raw) ? '0 : (free_raw - transit_q);
    full_d     = (capacity_d == '0);
    first_d    = full_d ? '0 : first_free(occ, transit_q);
  end

  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gcnt_q     <= '0;
      req_q      <= 1'b0;
      transit_q  <= '0;
      capacity_q <= MAX_TRANSIT;
      first_q    <= '0;
      full_q     <= 1'b0;
      deny_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gcnt_q     <= gcnt_d;
      req_q      <= entry_req;
      transit_q  <= transit_d;
      capacity_q <= capacity_d;
      first_q    <= first_d;
      full_q     <= full_d;
      deny_q     <= deny_d;
    end
  end

  assign capacity    = capacity_q;
  assign first_empty = first_q;
  assign full        = full_q;
  assign entry_deny  = deny_q;
  assign gate_open   = (state_q == ST_OPEN);

endmodule

// File: tb/tb_parking_occupancy.sv
// Bench for parking_occupancy: directed scenarios with literal expectations,
// then random sensor/entry traffic against a sample-window reference model.
module tb_parking_occupancy;

  localparam int D = 4;
  localparam int G = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sensor = 4'b0000;
  logic       req    = 1'b0;
  logic [2:0] capacity;
  logic [1:0] first_empty;
  logic       full, gate_open, entry_deny;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  parking_occupancy #(
    .DEBOUNCE_CYCLES(D),
    .GATE_CYCLES    (G)
  ) dut (
    .clk_500Hz  (clk),
    .reset      (rst_n),
    .slot_sensor(sensor),
    .entry_req  (req),
    .capacity   (capacity),
    .first_empty(first_empty),
    .full       (full),
    .gate_open  (gate_open),
    .entry_deny (entry_deny)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sensor sample history, accepted slot vector, cars in transit,
  // remaining gate-open cycles and the registered output values.
  logic [3:0] m_hist[$];
  logic [3:0] m_deb;
  int         m_transit, m_gate_left, m_cap, m_first;
  logic       m_prev_req, m_full, m_deny;

  function automatic int free_of(input logic [3:0] d);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) n++;
    return n;
  endfunction

  function automatic int nth_free(input logic [3:0] d, input int k);
    int q[$];
    for (int i = 0; i < 4; i++) if (!d[i]) q.push_back(i);
    return (k < q.size()) ? q[k] : 0;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < D + 1; i++) m_hist.push_back(4'b0000);
    m_deb       = 4'b0000;
    m_transit   = 0;
    m_gate_left = 0;
    m_cap       = 4;
    m_first     = 0;
    m_full      = 1'b0;
    m_deny      = 1'b0;
    m_prev_req  = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] nd;
    bit         rising, grant, any_rise, same;
    int         sz, fr;
    rising = req && !m_prev_req;
    grant  = (m_gate_left == 0) && rising && (m_cap > 0);
    m_deny = (m_gate_left == 0) && rising && (m_cap == 0);
    // The value seen after the synchroniser at this edge is the sensor from two
    // edges ago; a slot flips once its last D such samples all agree.
    sz = m_hist.size();
    for (int b = 0; b < 4; b++) begin
      same = 1'b1;
      for (int k = sz - 1 - D; k <= sz - 2; k++)
        if (m_hist[k][b] != m_hist[sz-2][b]) same = 1'b0;
      nd[b] = same ? m_hist[sz-2][b] : m_deb[b];
    end
    any_rise = |(nd & ~m_deb);
    fr       = free_of(m_deb);
    m_cap    = (m_transit > fr) ? 0 : fr - m_transit;
    m_full   = (m_cap == 0);
    m_first  = (m_cap == 0) ? 0 : nth_free(m_deb, m_transit);
    if (grant && !any_rise) m_transit = (m_transit < 4) ? m_transit + 1 : 4;
    else if (any_rise && !grant) m_transit = (m_transit > 0) ? m_transit - 1 : 0;
    m_gate_left = grant ? G : ((m_gate_left > 0) ? m_gate_left - 1 : 0);
    m_deb      = nd;
    m_prev_req = req;
    m_hist.push_back(sensor);
    void'(m_hist.pop_front());
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_capacity",    32'(capacity),    32'(m_cap));
      check("m_first_empty", 32'(first_empty), 32'(m_first));
      check("m_full",        32'(full),        32'(m_full));
      check("m_gate_open",   32'(gate_open),   32'(m_gate_left > 0));
      check("m_entry_deny",  32'(entry_deny),  32'(m_deny));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int open_cnt;

  initial begin
    model_reset();
    cyc(1);
    check("in_reset_cap",  32'(capacity),  32'd4);
    check("in_reset_full", 32'(full),      32'd0);
    check("in_reset_gate", 32'(gate_open), 32'd0);
    cyc(2);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(2);
    check("rst_cap",   32'(capacity),    32'd4);
    check("rst_first", 32'(first_empty), 32'd0);
    check("rst_full",  32'(full),        32'd0);
    check("rst_gate",  32'(gate_open),   32'd0);

    // Two slots occupied: latency of 2 + D edges, then registered capacity.
    sensor = 4'b0011;
    cyc(6);
    check("lat_cap_early", 32'(capacity), 32'd4);
    cyc(1);
    check("two_cap",   32'(capacity),    32'd2);
    check("two_first", 32'(first_empty), 32'd2);
    sensor = 4'b1011;
    cyc(3);
    sensor = 4'b0011;
    cyc(10);
    check("glitch_cap",   32'(capacity),    32'd2);
    check("glitch_first", 32'(first_empty), 32'd2);

    // Last free slot granted: gate open for G cycles, lot reads full.
    sensor = 4'b0111;
    cyc(8);
    check("one_cap",   32'(capacity),    32'd1);
    check("one_first", 32'(first_empty), 32'd3);
    req = 1'b1;
    open_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (gate_open) open_cnt++;
    end
    check("gate_len",     32'(open_cnt), 32'd10);
    check("granted_cap",  32'(capacity), 32'd0);
    check("granted_full", 32'(full),    32'd1);
    sensor = 4'b1111;
    cyc(8);
    check("parked_cap",  32'(capacity), 32'd0);
    check("parked_full", 32'(full),     32'd1);
    sensor = 4'b1110;
    cyc(8);
    check("leave_cap",   32'(capacity),    32'd1);
    check("leave_first", 32'(first_empty), 32'd0);

    // Entry refused while full.
    sensor = 4'b1111;
    cyc(8);
    check("full_cap", 32'(capacity), 32'd0);
    req = 1'b1;
    cyc(1);
    req = 1'b0;
    check("deny_pulse", 32'(entry_deny), 32'd1);
    check("deny_gate",  32'(gate_open),  32'd0);
    cyc(1);
    check("deny_end",   32'(entry_deny), 32'd0);

    // Grant in the same cycle as a slot becoming occupied.
    sensor = 4'b0000;
    cyc(10);
    check("empty_cap", 32'(capacity), 32'd4);
    sensor = 4'b0001;
    cyc(5);
    req = 1'b1;
    cyc(1);
    req = 1'b0;
    check("same_gate", 32'(gate_open), 32'd1);
    cyc(1);
    check("same_cap",  32'(capacity), 32'd3);

    // Reset pulsed while the gate is open.
    cyc(12);
    check("closed_gate", 32'(gate_open), 32'd0);
    req = 1'b1;
    cyc(1);
    req = 1'b0;
    cyc(2);
    check("open_gate", 32'(gate_open), 32'd1);
    check("open_cap",  32'(capacity),  32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_gate", 32'(gate_open), 32'd0);
    check("async_cap",  32'(capacity),  32'd4);
    #1 rst_n = 1'b1;
    cyc(9);
    check("post_rst_cap",   32'(capacity),    32'd3);
    check("post_rst_first", 32'(first_empty), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int b;
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        b = int'($urandom_range(0, 3));
        sensor[b] = ~sensor[b];
      end
      if ($urandom_range(0, 4) == 0) req = ~req;
      if (i == 1500) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
